// File: rtl/rom_read_ctrl.sv
// Block-read controller for a 16x8 registered ROM: fetches `count` words from
// base_addr upward, hands each to a valid/ready consumer and accumulates their sum.
module rom_read_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  base_addr,
  input  logic [4:0]  count,
  output logic [3:0]  addr,
  output logic        cs,
  output logic        rd,
  input  logic [7:0]  rom_data,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic [11:0] sum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] cur_addr;
  logic [4:0] remaining;
  logic       accept;

  assign accept = (state == S_OUT) && data_ready;
  assign addr   = cur_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= 4'd0;
      remaining <= 5'd0;
      data_out  <= 8'd0;
      sum       <= 12'd0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && start) begin
        cur_addr  <= base_addr;
        remaining <= count;
        sum       <= 12'd0;
      end
      // The ROM registered its output on the edge that ended REQ.
      if (state == S_WAIT) begin
        data_out <= rom_data;
      end
      if (accept) begin
        sum       <= sum + {4'd0, data_out};
        remaining <= remaining - 5'd1;
        cur_addr  <= cur_addr + 4'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    cs         = 1'b0;
    rd         = 1'b0;
    data_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = (count == 5'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        cs         = 1'b1;
        rd         = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        cs         = 1'b1;
        next_state = S_OUT;
      end
      S_OUT: begin
        data_valid = 1'b1;
        if (data_ready) begin
          next_state = (remaining == 5'd1) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_read_ctrl.sv
// Scoreboard bench for rom_read_ctrl: directed blocks push expected words and
// sums; a negedge monitor pops and compares whenever a word is accepted or done fires.
module tb_rom_read_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  base_addr = 4'd0;
  logic [4:0]  count = 5'd0;
  logic [3:0]  addr;
  logic        cs;
  logic        rd;
  logic [7:0]  rom_data = 8'd0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] sum;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int t0 = 0;
  int doneCyc = 0;

  logic [7:0]  expData[$];
  logic [11:0] expSum[$];
  int          acceptCyc[$];

  rom_read_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .addr(addr), .cs(cs), .rd(rd), .rom_data(rom_data), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done),
    .sum(sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM holding rom[a] = a + 3.
  always @(posedge clk) begin
    if (cs && rd) rom_data <= {4'd0, addr} + 8'd3;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: accepted words and done pulses are popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      acceptCyc.push_back(cyc);
      if (expData.size() == 0) checkOutput("unexpected word", {24'd0, data_out}, 32'hFFFF_FFFF);
      else checkOutput("data_out", {24'd0, data_out}, {24'd0, expData.pop_front()});
    end
    if (!rst && done) begin
      doneCyc = cyc;
      if (expSum.size() == 0) checkOutput("unexpected done", {20'd0, sum}, 32'hFFFF_FFFF);
      else checkOutput("sum at done", {20'd0, sum}, {20'd0, expSum.pop_front()});
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; afterwards t0 marks the cycle following that edge.
  task automatic applyStimulus(input logic [3:0] b, input logic [4:0] c, input logic [11:0] s, input bit expectDone);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    if (expectDone) expSum.push_back(s);
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) waitCycles(1);
    if (busy) checkOutput({name, " timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    waitCycles(3);
    checkOutput("reset addr", {28'd0, addr}, 32'd0);
    checkOutput("reset strobes", {29'd0, cs, rd, data_valid}, 32'd0);
    checkOutput("reset busy/done", {30'd0, busy, done}, 32'd0);
    checkOutput("reset data_out/sum", {12'd0, data_out, sum}, 32'd0);
    rst = 1'b0;
    waitCycles(1);

    // base 2, count 3: words 5,6,7, sum 18.
    data_ready = 1'b1;
    acceptCyc.delete();
    expData.push_back(8'd5); expData.push_back(8'd6); expData.push_back(8'd7);
    applyStimulus(4'd2, 5'd3, 12'd18, 1'b1);
    checkOutput("t1 REQ cs/rd/addr", {26'd0, cs, rd, addr}, {26'd0, 2'b11, 4'd2});
    waitCycles(1);
    checkOutput("t1 WAIT cs/rd", {30'd0, cs, rd}, {30'd0, 2'b10});
    waitCycles(1);
    checkOutput("t1 first valid", {23'd0, data_valid, data_out}, {23'd0, 1'b1, 8'd5});
    waitIdle("t1", 30);
    checkOutput("t1 word spacing", acceptCyc[1] - acceptCyc[0], 32'd3);
    checkOutput("t1 last spacing", acceptCyc[2] - acceptCyc[1], 32'd3);
    waitCycles(3);
    checkOutput("t1 sum held", {20'd0, sum}, 32'd18);

    // base 15, count 2: address wraps 15 -> 0, words 18,3, sum 21.
    expData.push_back(8'd18); expData.push_back(8'd3);
    applyStimulus(4'd15, 5'd2, 12'd21, 1'b1);
    checkOutput("t2 addr first", {28'd0, addr}, 32'd15);
    waitCycles(3);
    checkOutput("t2 addr wrapped", {27'd0, rd, addr}, {27'd0, 1'b1, 4'd0});
    waitIdle("t2", 30);

    // base 0, count 16: words 3..18, sum 168, done 48 cycles after first REQ.
    for (int i = 3; i <= 18; i++) expData.push_back(i[7:0]);
    applyStimulus(4'd0, 5'd16, 12'd168, 1'b1);
    waitIdle("t3", 100);
    checkOutput("t3 REQ to done", doneCyc - t0, 32'd48);

    // count 0: done right away, no ROM access, sum 0.
    applyStimulus(4'd5, 5'd0, 12'd0, 1'b1);
    checkOutput("t4 done pulse", {29'd0, done, cs, rd}, {29'd0, 3'b100});
    waitIdle("t4", 5);

    // Consumer stall: base 4, count 2 -> words 7,8, sum 15; start while busy ignored.
    data_ready = 1'b0;
    expData.push_back(8'd7); expData.push_back(8'd8);
    applyStimulus(4'd4, 5'd2, 12'd15, 1'b1);
    waitCycles(2);
    base_addr = 4'd9;
    count     = 5'd3;
    start     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5 stall hold", {21'd0, data_valid, cs, rd, data_out}, {21'd0, 3'b100, 8'd7});
      waitCycles(1);
    end
    start      = 1'b0;
    data_ready = 1'b1;
    waitIdle("t5", 30);
    waitCycles(3);
    checkOutput("t5 start not queued", {31'd0, busy}, 32'd0);

    // Reset during WAIT of the 2nd word of a 4-word block: only word 11 accepted.
    expData.push_back(8'd11);
    applyStimulus(4'd8, 5'd4, 12'd0, 1'b0);
    waitCycles(4);
    checkOutput("t6 in WAIT", {30'd0, cs, rd}, {30'd0, 2'b10});
    rst = 1'b1;
    waitCycles(1);
    checkOutput("t6 abort strobes", {27'd0, cs, rd, data_valid, busy, done}, 32'd0);
    checkOutput("t6 abort values", {8'd0, addr, data_out, sum}, 32'd0);
    rst = 1'b0;
    expData.push_back(8'd4);
    applyStimulus(4'd1, 5'd1, 12'd4, 1'b1);
    waitIdle("t6 restart", 20);

    waitCycles(2);
    checkOutput("words left over", expData.size(), 32'd0);
    checkOutput("sums left over", expSum.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
